// File: rtl/exec_unit_m.sv
`timescale 1ns/1ps
// Execute unit for the five-stage core: single-cycle base ALU ops plus RV32M
// multiply/divide. Long ops run behind a valid/ready handshake so EX can stall.
module exec_unit_m #(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);
    localparam int DW  = 2 * XLEN;
    localparam logic [SHW-1:0]  LAST     = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state;
    logic [SHW-1:0]  cnt;

    // Multiplier iteration state
    logic [DW-1:0]   acc;
    logic [DW-1:0]   mcand;
    logic [XLEN-1:0] mplier;
    logic            m_sgn_b;
    logic            m_hi;

    // Divider iteration state
    logic [XLEN-1:0] dvsr;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic            neg_q;
    logic            neg_r;
    logic            r_sel;

    // Accept-time decode
    logic            accept;
    logic            is_m;
    logic            is_div;
    logic            sgn_a;
    logic            sgn_b;
    logic            hi_sel;
    logic            div_sgn;
    logic            b_zero;
    logic            div_ovf;
    logic            done_now;
    logic [DW-1:0]   fast_prod;
    logic [XLEN-1:0] imm_res;

    // Per-iteration next values
    logic            it_last;
    logic [DW-1:0]   m_add;
    logic [DW-1:0]   mul_sum;
    logic [XLEN-1:0] mul_res;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] rem_diff;
    logic            d_ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] div_res;

    function automatic logic [XLEN-1:0] base_alu(
        input logic [3:0]      code,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [SHW-1:0]  sh;
        logic [XLEN-1:0] r;
        sh = b[SHW-1:0];
        case (code)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << sh;
            4'b0010: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0011: r = {{(XLEN-1){1'b0}}, (a < b)};
            4'b0100: r = a ^ b;
            4'b0101: r = a >> sh;
            4'b1101: r = $unsigned($signed(a) >>> sh);
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] ext2(input logic [XLEN-1:0] v, input logic sgn);
        return {{XLEN{sgn & v[XLEN-1]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // A base op may enter while the previous result is being consumed
    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Decode the incoming op and compute every single-cycle result
    always_comb begin
        is_m     = op[4];
        is_div   = op[4] & op[2];
        sgn_a    = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
        sgn_b    = (op[1:0] == 2'b01);
        hi_sel   = (op[1:0] != 2'b00);
        div_sgn  = ~op[0];
        b_zero   = (data2 == '0);
        div_ovf  = div_sgn && (data1 == MOST_NEG) && (data2 == '1);
        fast_prod = '0;
        if (FAST_MUL != 0) begin
            fast_prod = ext2(data1, sgn_a) * ext2(data2, sgn_b);
        end
        done_now = !is_m || ((FAST_MUL != 0) && !is_div) || (is_div && (b_zero || div_ovf));
        if (!is_m) begin
            imm_res = base_alu(op[3:0], data1, data2);
        end else if (!is_div) begin
            imm_res = hi_sel ? fast_prod[DW-1:XLEN] : fast_prod[XLEN-1:0];
        end else if (b_zero) begin
            imm_res = op[1] ? data1 : '1;
        end else begin
            imm_res = op[1] ? '0 : data1;
        end
    end

    // One shift-add / restoring-divide step; a signed multiplier's top bit has negative weight
    always_comb begin
        it_last  = (cnt == LAST);
        m_add    = mplier[0] ? mcand : '0;
        mul_sum  = (it_last && m_sgn_b) ? (acc - m_add) : (acc + m_add);
        mul_res  = m_hi ? mul_sum[DW-1:XLEN] : mul_sum[XLEN-1:0];
        rem_sh   = {rem, quo[XLEN-1]};
        rem_diff = rem_sh[XLEN-1:0] - dvsr;
        d_ge     = (rem_sh >= {1'b0, dvsr});
        rem_nx   = d_ge ? rem_diff : rem_sh[XLEN-1:0];
        quo_nx   = {quo[XLEN-2:0], d_ge};
        div_res  = r_sel ? neg_if(rem_nx, neg_r) : neg_if(quo_nx, neg_q);
    end

    // Control FSM with iteration datapath and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            m_sgn_b   <= 1'b0;
            m_hi      <= 1'b0;
            dvsr      <= '0;
            quo       <= '0;
            rem       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            r_sel     <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            if (done_now) begin
                state     <= S_DONE;
                out_valid <= 1'b1;
                result    <= imm_res;
            end else if (is_div) begin
                state     <= S_DIV;
                out_valid <= 1'b0;
                quo       <= neg_if(data1, div_sgn & data1[XLEN-1]);
                dvsr      <= neg_if(data2, div_sgn & data2[XLEN-1]);
                rem       <= '0;
                neg_q     <= div_sgn & (data1[XLEN-1] ^ data2[XLEN-1]);
                neg_r     <= div_sgn & data1[XLEN-1];
                r_sel     <= op[1];
            end else begin
                state     <= S_MUL;
                out_valid <= 1'b0;
                acc       <= '0;
                mcand     <= ext2(data1, sgn_a);
                mplier    <= data2;
                m_sgn_b   <= sgn_b;
                m_hi      <= hi_sel;
            end
        end else begin
            case (state)
                S_MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (it_last) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= mul_res;
                    end
                end
                S_DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + SHW'(1);
                    if (it_last) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= div_res;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit_m.sv
`timescale 1ns/1ps
// Directed bench for exec_unit_m: iterative and single-cycle multiply builds side by side.
module tb_exec_unit_m;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid_f = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  op = '0;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic        in_ready, out_valid, in_ready_f, out_valid_f;
    logic [31:0] result, result_f;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit          fast;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    exec_unit_m #(.XLEN(32), .FAST_MUL(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .data1(data1), .data2(data2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    exec_unit_m #(.XLEN(32), .FAST_MUL(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_f), .in_ready(in_ready_f), .op(op),
        .data1(data1), .data2(data2),
        .out_valid(out_valid_f), .out_ready(out_ready), .result(result_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add_v(input bit f, input logic [4:0] o, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] e, input int l);
        vec_t v;
        v.fast = f; v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l;
        vecs.push_back(v);
    endfunction

    // Issue one op, wait (bounded) for its result; lat=1 means valid right after the accept edge
    task automatic run_op(input bit fast, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int lat);
        @(posedge clk); #1;
        op = o; data1 = a; data2 = b;
        if (fast) in_valid_f = 1'b1; else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid_f = 1'b0;
        lat = 1;
        while (!(fast ? out_valid_f : out_valid) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = fast ? result_f : result;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          lat;
        bit          seen;

        // base ops
        add_v(0, 5'b00000, 32'd5,        32'hFFFFFFF9, 32'hFFFFFFFE, 1);
        add_v(0, 5'b01101, 32'h80000000, 32'd4,        32'hF8000000, 1);
        add_v(0, 5'b00011, 32'd1,        32'hFFFFFFFF, 32'd1,        1);
        add_v(0, 5'b00010, 32'hFFFFFFFF, 32'd1,        32'd1,        1);
        add_v(0, 5'b01000, 32'd3,        32'd5,        32'hFFFFFFFE, 1);
        add_v(0, 5'b00001, 32'd1,        32'h24,       32'h10,       1);
        add_v(0, 5'b00101, 32'h80000000, 32'd4,        32'h08000000, 1);
        add_v(0, 5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
        add_v(0, 5'b00110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1);
        add_v(0, 5'b00111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
        add_v(0, 5'b01111, 32'h12345678, 32'h1,        32'h0,        1);
        // iterative multiply
        add_v(0, 5'b10000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        add_v(0, 5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        add_v(0, 5'b10010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        add_v(0, 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        add_v(0, 5'b11000, 32'd6,        32'd7,        32'd42,       33);
        // single-cycle multiply
        add_v(1, 5'b10000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1);
        add_v(1, 5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 1);
        add_v(1, 5'b10010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1);
        add_v(1, 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
        // divide
        add_v(0, 5'b10100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        add_v(0, 5'b10110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        add_v(0, 5'b10101, 32'd100,      32'd7,        32'd14,       33);
        add_v(0, 5'b10111, 32'd100,      32'd7,        32'd2,        33);
        add_v(0, 5'b10110, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
        add_v(0, 5'b10101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
        add_v(0, 5'b10100, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1);
        add_v(0, 5'b10111, 32'h00001234, 32'd0,        32'h00001234, 1);
        add_v(0, 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        add_v(0, 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
        add_v(1, 5'b10101, 32'd100,      32'd7,        32'd14,       33);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_out_valid_f", {31'd0, out_valid_f}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].fast, vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
            chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // back-to-back adds, one accepted per cycle
        @(posedge clk); #1;
        op = 5'b00000; data1 = 32'd0; data2 = 32'd100; in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("b2b%0d_result", i), result, 32'(i - 1 + 100));
            chk($sformatf("b2b%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            data1 = 32'(i);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_last_result", result, 32'd104);

        // backpressure after a divide
        @(posedge clk); #1;
        out_ready = 1'b0;
        op = 5'b10101; data1 = 32'd100; data2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_result", k), result, 32'd14);
            chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
        end
        op = 5'b00000; data1 = 32'd2; data2 = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_add_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_add_result", result, 32'd5);

        // flush at iteration 10 of a divide
        @(posedge clk); #1;
        op = 5'b10100; data1 = 32'hFFFFFFF9; data2 = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("div_busy_in_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_result_kept", result, 32'd5);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", {31'd0, seen}, 32'd0);
        run_op(0, 5'b00000, 32'd1, 32'd2, r, lat);
        chk("post_flush_add", r, 32'd3);
        chk("post_flush_latency", 32'(lat), 32'd1);

        // flush wins over a same-cycle accept
        @(posedge clk); #1;
        op = 5'b00000; data1 = 32'd9; data2 = 32'd9; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_accept_result", result, 32'd3);
        @(posedge clk); #1;
        chk("flush_accept_valid2", {31'd0, out_valid}, 32'd0);

        // asynchronous reset in the middle of a multiply
        op = 5'b10000; data1 = 32'd7; data2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 5'b00000, 32'd2, 32'd2, r, lat);
        chk("post_rst_add", r, 32'd4);
        chk("post_rst_latency", 32'(lat), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_unit_m.md
Name: exec_unit_m

Overview:
- Parametrised execute unit for the five-stage core. Replaces the single-cycle ALU in EX.
- Keeps all base integer ALU ops and their encodings, and adds the RV32M multiply/divide ops.
- Multi-cycle ops run behind a valid/ready handshake so EX can stall the pipeline.
- Has a flush input so branch redirects can kill an op that is in flight.

Parameters:
- XLEN, 32: datapath width. Must be a power of 2 and at least 8.
- FAST_MUL, 0: 1 = MUL/MULH* computed in one cycle, like base ops. 0 = iterative shift-add over XLEN cycles.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill current op; synchronous
- in_valid  in  1  operands and op valid
- in_ready  out  1  unit can accept an op
- op  in  5  op[4]=0: base op, op[3:0] is the base ALU code. op[4]=1: M op, op[2:0] = funct3.
- data1  in  XLEN  rs1 operand
- data2  in  XLEN  rs2 operand or immediate
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  XLEN  result value

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; result=0; in_ready=1 once reset is released.
  - All internal iteration registers cleared.
- Base ops (op[4]=0), codes unchanged from the existing ALU:
  - 0000 add; 1000 sub; 0001 sll; 0010 slt (signed); 0011 sltu; 0100 xor; 0101 srl; 1101 sra; 0110 or; 0111 and; any other code gives 0.
  - Shift amount is data2[log2(XLEN)-1:0].
  - slt/sltu return 1 or 0, zero-extended to XLEN.
- M ops (op[4]=1, op[2:0]):
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH: high XLEN bits, signed × signed.
  - 010 MULHSU: high XLEN bits, signed data1 × unsigned data2.
  - 011 MULHU: high XLEN bits, unsigned × unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - op[3] is ignored.
- Handshake:
  - Accept when in_valid && in_ready at a rising edge.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - So a base op can be accepted in the same cycle the previous result is consumed.
  - Operands are captured at accept; inputs may change afterwards.
- State machine: IDLE, MUL, DIV, DONE.
  - Accept a base op, or any M op when FAST_MUL=1 and op[2]=0: go to DONE. Result is registered, so out_valid rises the cycle after accept (latency 1).
  - Accept an M op with op[2]=0 and FAST_MUL=0: go to MUL.
    - Operands are sign- or zero-extended to 2*XLEN by op.
    - XLEN iterations, one per cycle. Then go to DONE.
    - out_valid rises XLEN+1 cycles after accept.
  - Accept an M op with op[2]=1: go to DIV.
    - Operands converted to magnitudes for signed ops.
    - Unsigned restoring divide, XLEN iterations, one per cycle. Then go to DONE.
    - out_valid rises XLEN+1 cycles after accept.
    - Signed fixup: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - DONE: result held stable and out_valid=1 until out_ready.
    - out_ready with no new accept: go to IDLE, out_valid=0.
    - out_ready with a new accept: go to the new op's state.
- Division special cases (early out, go straight to DONE, latency 1):
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give data1.
  - Signed overflow (data1 = most-negative value, data2 = -1): DIV gives data1; REM gives 0.
- Flush:
  - Any state goes to IDLE next cycle; out_valid=0; result keeps its old value. The killed result is never presented.
  - flush overrides an accept in the same cycle: the op is dropped.
  - in_ready stays as computed; upstream must not rely on an accept during flush.
- Stability:
  - While out_valid=1 and out_ready=0, result must not change.
  - In MUL/DIV, in_ready=0 and out_valid=0.
- Reset mid-op (rst_n low in MUL/DIV): immediate return to reset values; no result produced.

Test Plan:
- Base ops, XLEN=32, out_ready=1:
  - add 5+(-7) gives 0xFFFFFFFE one cycle after accept.
  - sra 0x80000000 by 4 gives 0xF8000000.
  - sltu 1 vs 0xFFFFFFFF gives 1.
  - Back-to-back accepts every cycle with no bubble.
- Multiply, FAST_MUL=0:
  - MUL 7 × -3 gives 0xFFFFFFEB at cycle 33.
  - MULH 0x80000000 × 0x80000000 gives 0x40000000.
  - MULHSU -1 × 2 gives 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE.
  - Repeat with FAST_MUL=1: latency 1.
- Divide:
  - DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIVU 100/7 gives 14, at cycle 33.
  - DIV x/0 gives 0xFFFFFFFF at latency 1; REMU x/0 gives x at latency 1.
  - DIV 0x80000000/-1 gives 0x80000000; REM of the same gives 0.
- Backpressure: hold out_ready=0 for 5 cycles after a DIV completes.
  - result stays stable and in_ready=0.
  - Raise out_ready with a new add pending: add accepted that cycle, add result next cycle.
- Flush and reset:
  - flush at iteration 10 of a DIV: out_valid never rises, in_ready=1 next cycle, a following add completes normally.
  - rst_n low mid-MUL: out_valid=0 and result=0 immediately (asynchronous).
